// File: rtl/exec_stage_mc.sv
// ---------------------------------------------------------------------------
// exec_stage_mc
// Execute stage sitting between operand fetch and writeback. An integer ALU,
// a bypass from an external shifter and an iterative one-bit-per-cycle shift
// unit all feed a single write-enabled result register. A valid/ready
// handshake lets the iterative shifter stall the front end.
//
// Parameters
//   WIDTH      datapath width in bits (>= 4)
//   SHIFT_W    shift-amount width, equal to clog2(WIDTH)
//
// Ports
//   CLK         in   rising-edge clock
//   RST_N       in   asynchronous active-low reset
//   in_valid    in   operation offered this cycle
//   in_ready    out  stage can accept (accepted when in_valid && in_ready)
//   ALUInA      in   operand A
//   ALUInB      in   operand B; low SHIFT_W bits are the iterative shift amount
//   ALUop       in   ALU operation select
//   ShiftOp     in   iterative shift kind: 0 SLL, 1 SRL, 2 SRA, 3 ROL
//   ShifterOut  in   external shifter result (bypass source)
//   ResSource   in   0 ALU, 1 ShifterOut, 2 iterative shifter, 3 ALU
//   ResWrite    in   result register write enable for this operation
//   ResOut      out  result register
//   isZero      out  registered (ResOut == 0)
//   out_valid   out  one-cycle completion pulse
//   busy        out  iterative shift in progress (inverse of in_ready)
// ---------------------------------------------------------------------------
module exec_stage_mc #(
    parameter int WIDTH   = 16,
    parameter int SHIFT_W = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   ALUInA,
    input  logic [WIDTH-1:0]   ALUInB,
    input  logic [3:0]         ALUop,
    input  logic [1:0]         ShiftOp,
    input  logic [WIDTH-1:0]   ShifterOut,
    input  logic [1:0]         ResSource,
    input  logic               ResWrite,
    output logic [WIDTH-1:0]   ResOut,
    output logic               isZero,
    output logic               out_valid,
    output logic               busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [WIDTH-1:0]     r_work;
    logic [SHIFT_W-1:0]   r_cnt;
    logic [1:0]           r_kind;
    logic                 r_write;

    logic [WIDTH-1:0]     w_aluRes;
    logic [WIDTH-1:0]     w_shiftStep;
    logic [WIDTH-1:0]     w_result;
    logic [SHIFT_W-1:0]   w_amount;
    logic                 w_loadShift;
    logic                 w_complete;
    logic                 w_writeEn;

    assign w_amount = ALUInB[SHIFT_W-1:0];

    // Ready depends only on the registered state, so there is no
    // combinational path from in_valid to in_ready.
    assign in_ready = (r_state == ST_IDLE);
    assign busy     = ~in_ready;

    // Integer ALU; carries are discarded and unused opcodes yield zero.
    always_comb begin
        w_aluRes = '0;
        case (ALUop)
            4'd0: w_aluRes = ALUInA + ALUInB;
            4'd1: w_aluRes = ALUInA - ALUInB;
            4'd2: w_aluRes = ALUInA & ALUInB;
            4'd3: w_aluRes = ALUInA | ALUInB;
            4'd4: w_aluRes = ALUInA ^ ALUInB;
            4'd5: w_aluRes = ~(ALUInA | ALUInB);
            4'd6: w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(ALUInA) < $signed(ALUInB))};
            4'd7: w_aluRes = {{(WIDTH-1){1'b0}}, (ALUInA < ALUInB)};
            4'd8: w_aluRes = ALUInA;
            4'd9: w_aluRes = ALUInB;
            default: w_aluRes = '0;
        endcase
    end

    // One-position step of the iterative shifter for the latched shift kind.
    always_comb begin
        w_shiftStep = r_work;
        case (r_kind)
            2'd0: w_shiftStep = {r_work[WIDTH-2:0], 1'b0};
            2'd1: w_shiftStep = {1'b0, r_work[WIDTH-1:1]};
            2'd2: w_shiftStep = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_shiftStep = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
        endcase
    end

    // Next-state and completion decode. Single-cycle operations (including an
    // iterative shift by zero, which is just operand A) complete at the
    // acceptance edge; a non-zero shift parks in SHIFT until its count runs out.
    always_comb begin
        w_nextState = r_state;
        w_loadShift = 1'b0;
        w_complete  = 1'b0;
        w_writeEn   = 1'b0;
        w_result    = '0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if ((ResSource == 2'd2) && (w_amount != '0)) begin
                        w_loadShift = 1'b1;
                        w_nextState = ST_SHIFT;
                    end else begin
                        w_complete = 1'b1;
                        w_writeEn  = ResWrite;
                        case (ResSource)
                            2'd1:    w_result = ShifterOut;
                            2'd2:    w_result = ALUInA;
                            default: w_result = w_aluRes;
                        endcase
                    end
                end
            end
            ST_SHIFT: begin
                if (r_cnt == SHIFT_W'(1)) begin
                    w_complete  = 1'b1;
                    w_writeEn   = r_write;
                    w_result    = w_shiftStep;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // State, shifter working registers and the result/flag registers. The
    // write enable of a multi-cycle shift is captured at acceptance so later
    // changes on ResWrite cannot affect it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_work    <= '0;
            r_cnt     <= '0;
            r_kind    <= 2'd0;
            r_write   <= 1'b0;
            ResOut    <= '0;
            isZero    <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            out_valid <= w_complete;
            if (w_loadShift) begin
                r_work  <= ALUInA;
                r_cnt   <= w_amount;
                r_kind  <= ShiftOp;
                r_write <= ResWrite;
            end else if (r_state == ST_SHIFT) begin
                r_work <= w_shiftStep;
                r_cnt  <= r_cnt - SHIFT_W'(1);
            end
            if (w_complete && w_writeEn) begin
                ResOut <= w_result;
                isZero <= (w_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_mc.sv
// ---------------------------------------------------------------------------
// tb_exec_stage_mc
// Self-checking bench for exec_stage_mc. A 16-bit instance receives directed
// and random operations compared against an arithmetic reference model; a
// 32-bit instance runs the longest shift for that width.
// ---------------------------------------------------------------------------
module tb_exec_stage_mc;

    logic        CLK;
    logic        RST_N;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ALUInA;
    logic [15:0] ALUInB;
    logic [3:0]  ALUop;
    logic [1:0]  ShiftOp;
    logic [15:0] ShifterOut;
    logic [1:0]  ResSource;
    logic        ResWrite;
    logic [15:0] ResOut;
    logic        isZero;
    logic        out_valid;
    logic        busy;

    logic        v32InValid;
    logic        v32InReady;
    logic [31:0] v32A;
    logic [31:0] v32B;
    logic [31:0] v32ShOut;
    logic [31:0] v32ResOut;
    logic        v32IsZero;
    logic        v32OutValid;
    logic        v32Busy;

    int          checkCount;
    int          errorCount;
    logic [15:0] expRes;

    exec_stage_mc #(.WIDTH(16), .SHIFT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
        .ALUInA(ALUInA), .ALUInB(ALUInB), .ALUop(ALUop), .ShiftOp(ShiftOp),
        .ShifterOut(ShifterOut), .ResSource(ResSource), .ResWrite(ResWrite),
        .ResOut(ResOut), .isZero(isZero), .out_valid(out_valid), .busy(busy)
    );

    exec_stage_mc #(.WIDTH(32), .SHIFT_W(5)) dut32 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(v32InValid), .in_ready(v32InReady),
        .ALUInA(v32A), .ALUInB(v32B), .ALUop(4'd0), .ShiftOp(2'd0),
        .ShifterOut(v32ShOut), .ResSource(2'd2), .ResWrite(1'b1),
        .ResOut(v32ResOut), .isZero(v32IsZero), .out_valid(v32OutValid), .busy(v32Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference result of one operation, straight from the operation table.
    function automatic logic [15:0] refResult(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] op, input logic [1:0] sop,
                                              input logic [1:0] src, input logic [15:0] sh);
        int unsigned n;
        int unsigned ua;
        int unsigned ub;
        logic [15:0] r;
        ua = a;
        ub = b;
        n  = b[3:0];
        r  = 16'h0;
        if (src == 2'd1) begin
            r = sh;
        end else if (src == 2'd2) begin
            case (sop)
                2'd0: r = 16'((ua << n) & 32'hFFFF);
                2'd1: r = 16'(ua >> n);
                2'd2: r = 16'($signed(a) >>> n);
                default: r = 16'(((ua << n) | (ua >> (16 - n))) & 32'hFFFF);
            endcase
        end else begin
            case (op)
                4'd0: r = 16'((ua + ub) % 65536);
                4'd1: r = 16'((ua + 65536 - ub) % 65536);
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd4: r = a ^ b;
                4'd5: r = ~(a | b);
                4'd6: r = (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
                4'd7: r = (ua < ub) ? 16'd1 : 16'd0;
                4'd8: r = a;
                4'd9: r = b;
                default: r = 16'h0;
            endcase
        end
        return r;
    endfunction

    // Offers one operation, follows it through any stall and checks completion.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                                 input logic [1:0] sop, input logic [1:0] src,
                                 input logic [15:0] sh, input logic wr);
        int n;
        logic [15:0] r;
        r = refResult(a, b, op, sop, src, sh);
        n = (src == 2'd2) ? int'(b[3:0]) : 0;
        checkOutput("ready_at_offer", in_ready, 1);
        ALUInA = a; ALUInB = b; ALUop = op; ShiftOp = sop;
        ResSource = src; ShifterOut = sh; ResWrite = wr; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        ALUInA = 16'($urandom); ALUInB = 16'($urandom); ResWrite = ~wr;
        ShifterOut = 16'($urandom); ShiftOp = 2'($urandom); ResSource = 2'($urandom);
        for (int k = 0; k < n; k++) begin
            checkOutput("busy_stall", busy, 1);
            checkOutput("no_valid_stall", out_valid, 0);
            @(posedge CLK); #1;
        end
        if (wr) expRes = r;
        checkOutput("out_valid", out_valid, 1);
        checkOutput("ResOut", ResOut, expRes);
        checkOutput("isZero", isZero, (expRes == 16'h0));
        checkOutput("ready_after", in_ready, 1);
    endtask

    task automatic idleCycle();
        @(posedge CLK); #1;
        checkOutput("idle_no_valid", out_valid, 0);
        checkOutput("idle_hold", ResOut, expRes);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        expRes     = 16'h0;
        RST_N = 1'b0; in_valid = 1'b0;
        ALUInA = '0; ALUInB = '0; ALUop = '0; ShiftOp = '0;
        ShifterOut = '0; ResSource = '0; ResWrite = 1'b0;
        v32InValid = 1'b0; v32A = '0; v32B = '0; v32ShOut = '0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        checkOutput("rst_resout", ResOut, 0);
        checkOutput("rst_iszero", isZero, 1);
        checkOutput("rst_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);

        // Asynchronous reset while out_valid is high and ResOut is non-zero.
        applyStimulus(16'h0003, 16'h0004, 4'd0, 2'd0, 2'd0, 16'h0, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        expRes = 16'h0;
        checkOutput("async_rst_resout", ResOut, 0);
        checkOutput("async_rst_iszero", isZero, 1);
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_ready", in_ready, 1);
        #2 RST_N = 1'b1;
        @(posedge CLK); #1;

        // ALU back-to-back.
        applyStimulus(16'h7FFF, 16'h0001, 4'd0, 2'd0, 2'd0, 16'h0, 1'b1);
        checkOutput("add_value", ResOut, 16'h8000);
        applyStimulus(16'h0005, 16'h0005, 4'd1, 2'd0, 2'd0, 16'h0, 1'b1);
        checkOutput("sub_zero", isZero, 1);
        idleCycle();

        // Iterative SRA with the next operation held on in_valid during the stall.
        ALUInA = 16'h8000; ALUInB = 16'h0003; ALUop = 4'd0; ShiftOp = 2'd2;
        ResSource = 2'd2; ResWrite = 1'b1; in_valid = 1'b1;
        @(posedge CLK); #1;
        ALUInA = 16'h0001; ALUInB = 16'h0002; ALUop = 4'd0; ResSource = 2'd0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("sra_ready_low", in_ready, 0);
            checkOutput("sra_no_valid", out_valid, 0);
            checkOutput("sra_hold", ResOut, expRes);
            @(posedge CLK); #1;
        end
        expRes = 16'hF000;
        checkOutput("sra_valid", out_valid, 1);
        checkOutput("sra_result", ResOut, 16'hF000);
        checkOutput("sra_ready_back", in_ready, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        expRes = 16'h0003;
        checkOutput("held_op_valid", out_valid, 1);
        checkOutput("held_op_result", ResOut, 16'h0003);
        idleCycle();

        // ROL and zero-amount shift.
        applyStimulus(16'h8001, 16'h0001, 4'd0, 2'd3, 2'd2, 16'h0, 1'b1);
        checkOutput("rol_value", ResOut, 16'h0003);
        applyStimulus(16'h1234, 16'h0000, 4'd0, 2'd0, 2'd2, 16'h0, 1'b1);
        checkOutput("shift0_value", ResOut, 16'h1234);

        // Bypass with and without write enable.
        applyStimulus(16'h0, 16'h0, 4'd0, 2'd0, 2'd1, 16'hABCD, 1'b0);
        checkOutput("nowrite_hold", ResOut, 16'h1234);
        applyStimulus(16'h0, 16'h0, 4'd0, 2'd0, 2'd1, 16'hABCD, 1'b1);
        checkOutput("bypass_value", ResOut, 16'hABCD);
        idleCycle();

        // Reset in the middle of a long shift.
        ALUInA = 16'h0001; ALUInB = 16'h000F; ShiftOp = 2'd0;
        ResSource = 2'd2; ResWrite = 1'b1; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        expRes = 16'h0;
        checkOutput("midrst_resout", ResOut, 0);
        checkOutput("midrst_ready", in_ready, 1);
        #1 RST_N = 1'b1;
        for (int k = 0; k < 14; k++) idleCycle();

        // Randomised operations against the reference model.
        for (int t = 0; t < 150; t++) begin
            applyStimulus(16'($urandom), 16'($urandom), 4'($urandom), 2'($urandom),
                          2'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 4) == 0) idleCycle();
        end

        // 32-bit build: longest shift.
        v32A = 32'h0000_0001; v32B = 32'd31; v32InValid = 1'b1;
        @(posedge CLK); #1;
        v32InValid = 1'b0;
        checkOutput("w32_busy", v32Busy, 1);
        repeat (31) @(posedge CLK);
        #1;
        checkOutput("w32_valid", v32OutValid, 1);
        checkOutput("w32_result", v32ResOut, 32'h8000_0000);
        checkOutput("w32_iszero", v32IsZero, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
